d2t_toggle_reg: RTL
===================

D2T_TOGGLE_REG -- requirements
Module: d2t_toggle_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the number of toggle-register bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port clr, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port pre, input, 1 bit: synchronous preset, active-high, drives all q bits to 1.
REQ-005 SHALL have port cmd_valid, input, 1 bit: command offered.
REQ-006 SHALL have port cmd_ready, output, 1 bit: command can be accepted.
REQ-007 SHALL have port cmd_op, input, 2 bits: 00 toggle, 01 set, 10 clear, 11 load.
REQ-008 SHALL have port cmd_mask, input, WIDTH bits: operand mask.
REQ-009 SHALL have port rsp_valid, output, 1 bit: response available.
REQ-010 SHALL have port rsp_ready, input, 1 bit: response consumed.
REQ-011 SHALL have port rsp_prev, output, WIDTH bits: q value just before the executed command.
REQ-012 SHALL have ports q and qbar, outputs, WIDTH bits each: register state and its complement (qbar == ~q always).
REQ-013 SHALL have port op_count, output, 16 bits: count of executed commands, saturating.

Function
REQ-014 SHALL build every q bit as a T flip-flop made from a D flop, with next d = t ^ q.
REQ-015 SHALL run an FSM with states IDLE, EXEC and RESP; cmd_ready = 1 only in IDLE.
REQ-016 SHALL, in IDLE with cmd_valid = 1, capture cmd_op and cmd_mask at that edge and move to EXEC.
REQ-017 SHALL, in EXEC, derive the per-bit t vector from the captured op: toggle t = mask; set t = mask & ~q; clear t = mask & q; load t = mask ^ q.
REQ-018 SHALL, at the end-of-EXEC edge, update q <= q ^ t, load rsp_prev <= old q, increment op_count and move to RESP.
REQ-019 SHALL hold op_count at 0xFFFF once it reaches that value (no wrap).
REQ-020 SHALL hold rsp_valid = 1 throughout RESP; rsp_prev SHALL stay stable until rsp_ready = 1, then the FSM moves to IDLE.
REQ-021 SHALL make q change one edge after the accept edge; minimum cycle is 3 clocks per command; the block SHALL NOT accept a command while in EXEC or RESP.
REQ-022 SHALL, when pre = 1 (and clr = 0), force q to all ones in any state, overriding the EXEC update; rsp_prev capture, op_count and FSM progress SHALL be unaffected.

Reset
REQ-023 SHALL, when clr = 1, set q = 0, qbar = all ones, rsp_prev = 0, op_count = 0, rsp_valid = 0, FSM = IDLE.
REQ-024 SHALL give clr priority over pre and over any command.
REQ-025 SHALL, on clr in EXEC or RESP, abandon the in-flight command without emitting a response.

Configuration
REQ-026 SHALL, with macro D2T_PARITY_EN defined, add output parity (1 bit) = XOR of q (combinational) and output rsp_parity = XOR of rsp_prev.
REQ-027 SHALL, without D2T_PARITY_EN, omit both ports and their logic.

Structure
REQ-028 SHALL place the cmd_op encoding enum, the FSM state enum and the op_count width constant (16) in shared package d2t_pkg.
REQ-029 SHALL instantiate sub-module t_from_d_cell (one D flop plus t ^ q feedback, with synchronous clr/pre) WIDTH times via generate.

Verification
REQ-030 SHALL cover reset: clr = 1 for 1 cycle -> q = 0x00, qbar = 0xFF, op_count = 0, cmd_ready = 1, rsp_valid = 0.
REQ-031 SHALL cover toggles: toggle 0xA5 from 0x00 -> q = 0xA5, rsp_prev = 0x00; then toggle 0xFF -> q = 0x5A, rsp_prev = 0xA5, op_count = 2.
REQ-032 SHALL cover set, clear and load: set 0x0F on 0x5A -> 0x5F; clear 0x50 -> 0x0F; load 0x3C -> 0x3C; rsp_prev = 0x5A, 0x5F, 0x0F respectively.
REQ-033 SHALL cover backpressure: rsp_ready = 0 for 5 cycles with a second cmd_valid held -> rsp_valid and rsp_prev stable, cmd_ready = 0, second command accepted only after the response handshake.
REQ-034 SHALL cover pre and clr collisions: pre = 1 during EXEC of clear 0xFF -> q = 0xFF, rsp_prev = old q; clr during RESP -> rsp_valid = 0, q = 0, FSM in IDLE next cycle.
REQ-035 SHALL cover saturation: 65537 commands -> op_count = 0xFFFF; with D2T_PARITY_EN defined and q = 0x07 -> parity = 1.

Source files
------------

// File: rtl/d2t_pkg.sv
// Shared types and constants for the d2t toggle register.
package d2t_pkg;

    // Command encoding carried on cmd_op.
    typedef enum logic [1:0] {
        OpToggle = 2'b00,
        OpSet    = 2'b01,
        OpClear  = 2'b10,
        OpLoad   = 2'b11
    } op_e;

    // Command sequencer states.
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StExec = 2'b01,
        StResp = 2'b10
    } state_e;

    localparam int unsigned OpCountWidth = 16;
    localparam logic [OpCountWidth-1:0] OpCountMax = {OpCountWidth{1'b1}};

    // Per-bit toggle enable that turns the current bit into the value the op asks for.
    function automatic logic t_bit(op_e op, logic mask, logic cur);
        logic t;
        case (op)
            OpToggle: t = mask;
            OpSet:    t = mask & ~cur;
            OpClear:  t = mask & cur;
            OpLoad:   t = mask ^ cur;
            default:  t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/t_from_d_cell.sv
// One T flip-flop built from a D flop with t ^ q feedback; clr beats pre beats t.
module t_from_d_cell (
    input  logic clk,
    input  logic clr,
    input  logic pre,
    input  logic t,
    output logic q
);

    logic state_q;
    logic d;

    assign d = t ^ state_q;
    assign q = state_q;

    // D flop with synchronous clear and preset.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= 1'b0;
        end else if (pre) begin
            state_q <= 1'b1;
        end else begin
            state_q <= d;
        end
    end

endmodule

// File: rtl/d2t_toggle_reg.sv
// Command-driven toggle register: IDLE accepts, EXEC applies q ^ t, RESP holds the old q.
// Optional parity outputs are enabled with `define D2T_PARITY_EN.
module d2t_toggle_reg
    import d2t_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    pre,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [WIDTH-1:0]        cmd_mask,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [WIDTH-1:0]        rsp_prev,
    output logic [WIDTH-1:0]        q,
    output logic [WIDTH-1:0]        qbar,
    output logic [OpCountWidth-1:0] op_count
`ifdef D2T_PARITY_EN
    ,
    output logic                    parity,
    output logic                    rsp_parity
`endif
);

    state_e                  state_q;
    op_e                     op_q;
    logic [WIDTH-1:0]        mask_q;
    logic [WIDTH-1:0]        rsp_prev_q;
    logic                    cmd_ready_q;
    logic                    rsp_valid_q;
    logic [OpCountWidth-1:0] op_count_q;
    logic [OpCountWidth-1:0] op_count_d;
    logic [WIDTH-1:0]        t;

    // t is only non-zero during EXEC, so q moves exactly once per command.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign t[i] = (state_q == StExec) ? t_bit(op_q, mask_q[i], q[i]) : 1'b0;

        t_from_d_cell u_cell (
            .clk (clk),
            .clr (clr),
            .pre (pre),
            .t   (t[i]),
            .q   (q[i])
        );
    end

    assign qbar      = ~q;
    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_prev  = rsp_prev_q;
    assign op_count  = op_count_q;

    // Saturating count of executed commands.
    always_comb begin
        op_count_d = op_count_q;
        if (state_q == StExec && op_count_q != OpCountMax) begin
            op_count_d = op_count_q + OpCountWidth'(1);
        end
    end

    // Counter register, written every cycle from its next-state value.
    always_ff @(posedge clk) begin
        if (clr) begin
            op_count_q <= '0;
        end else begin
            op_count_q <= op_count_d;
        end
    end

    // Command sequencer with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= StIdle;
            op_q        <= OpToggle;
            mask_q      <= '0;
            rsp_prev_q  <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        op_q        <= op_e'(cmd_op);
                        mask_q      <= cmd_mask;
                        cmd_ready_q <= 1'b0;
                        state_q     <= StExec;
                    end
                end
                StExec: begin
                    // q is still the pre-command value at this edge.
                    rsp_prev_q  <= q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

`ifdef D2T_PARITY_EN
    assign parity     = ^q;
    assign rsp_parity = ^rsp_prev_q;
`endif

endmodule
